// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the CPU pipeline and muldiv_unit.
//   start/funct3/op_a/op_b/rd_in : request from the pipeline (master drives)
//   busy                         : stall while the unit is working
//   done/result/rd_out/reg_write : one-cycle write-back to the register file
interface muldiv_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      rd_in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;
    logic            reg_write;

    modport master (
        output start, funct3, op_a, op_b, rd_in,
        input  busy, done, result, rd_out, reg_write
    );

    modport slave (
        input  start, funct3, op_a, op_b, rd_in,
        output busy, done, result, rd_out, reg_write
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
//   clk, rst : clock and synchronous active-high reset
//   bus      : muldiv_if.slave (request in, busy/done/result/rd_out/reg_write out)
// One shift-add (multiply) or restoring shift-subtract (divide) step per cycle
// on operand magnitudes; signs are re-applied on the final step. Divide by zero
// and signed overflow bypass the iteration and complete immediately.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);
    localparam int unsigned CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t          state, state_d;
    logic [CW-1:0]   cnt;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] hi, lo, opnd;
    logic            neg_main, neg_rem;
    logic [XLEN-1:0] result_q;
    logic [4:0]      rd_q;

    // request decode
    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            is_div, div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;

    // iteration step
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [XLEN-1:0]   hi_d, lo_d;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quot_s, rem_s, final_res;
    logic              last_step;

    always_comb begin
        is_div      = bus.funct3[2];
        // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM treat rs2 as signed
        a_signed    = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                      (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        b_signed    = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                      (bus.funct3 == 3'b110);
        a_neg       = a_signed && bus.op_a[XLEN-1];
        b_neg       = b_signed && bus.op_b[XLEN-1];
        a_mag       = a_neg ? -bus.op_a : bus.op_a;
        b_mag       = b_neg ? -bus.op_b : bus.op_b;
        div_zero    = is_div && (bus.op_b == '0);
        div_ovf     = is_div && !bus.funct3[0] &&
                      (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b == '1);
        special     = div_zero || div_ovf;
        special_res = '0;
        if (div_zero) begin
            special_res = bus.funct3[1] ? bus.op_a : '1;
        end else if (div_ovf) begin
            special_res = bus.funct3[1] ? '0 : bus.op_a;
        end
    end

    always_comb begin
        // hi/lo hold {product_hi, multiplier} for multiply, {remainder, quotient} for divide
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        div_shift = {hi, lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (f3_q[2]) begin
            if (!div_diff[XLEN]) begin
                hi_d = div_diff[XLEN-1:0];
                lo_d = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_d = div_shift[XLEN-1:0];
                lo_d = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_d = mul_sum[XLEN:1];
            lo_d = {mul_sum[0], lo[XLEN-1:1]};
        end
        prod   = {hi_d, lo_d};
        prod_s = neg_main ? -prod : prod;
        quot_s = neg_main ? -lo_d : lo_d;
        rem_s  = neg_rem ? -hi_d : hi_d;
        if (f3_q[2]) begin
            final_res = f3_q[1] ? rem_s : quot_s;
        end else begin
            final_res = (f3_q == 3'b000) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        end
        last_step = (cnt == CW'(XLEN - 1));
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: if (bus.start) state_d = special ? S_DONE : S_CALC;
            S_CALC: if (last_step) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            f3_q     <= '0;
            hi       <= '0;
            lo       <= '0;
            opnd     <= '0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            result_q <= '0;
            rd_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        f3_q     <= bus.funct3;
                        rd_q     <= bus.rd_in;
                        cnt      <= '0;
                        hi       <= '0;
                        lo       <= is_div ? a_mag : b_mag;
                        opnd     <= is_div ? b_mag : a_mag;
                        neg_main <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        if (special) result_q <= special_res;
                    end
                end
                S_CALC: begin
                    hi  <= hi_d;
                    lo  <= lo_d;
                    cnt <= cnt + 1'b1;
                    if (last_step) result_q <= final_res;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_DONE);
    assign bus.result    = result_q;
    assign bus.rd_out    = rd_q;
    assign bus.reg_write = (state == S_DONE) && (rd_q != 5'd0);
endmodule
